// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the elastic inter-stage pipeline register.
//   - default control width and the bit position of each EX/MEM control field
//   - default data-word count and width for a stage
//   - entry-state encoding and an occupancy decode helper
package pipe_pkg;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int NDATA_DEF  = 3;

  // EX/MEM control-vector layout (MSB first)
  localparam int CB_REG_WRITE = 7;
  localparam int CB_ALU_SRC   = 6;
  localparam int CB_ALU_OP_HI = 5;
  localparam int CB_ALU_OP_LO = 3;
  localparam int CB_MEM_WRITE = 2;
  localparam int CB_MEM_READ  = 1;
  localparam int CB_REG_STORE = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ST_FULL1: occ_of = 2'd1;
      ST_FULL2: occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one ctrl+data holding register.
//   clk    - clock, updates on posedge
//   rst    - synchronous active-high reset, zeroes the entry
//   clr    - synchronous clear (flush), zeroes the entry
//   load   - capture ctrl_d/data_d
//   ctrl_d, data_d - next payload
//   ctrl_q, data_q - held payload
// Priority: rst > clr > load > hold.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DW     = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DW-1:0]     data_d,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DW-1:0]     data_q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register carrying one control
// vector plus NDATA data words between two stages.
//   CLK, Reset       - clock and synchronous active-high reset
//   flush            - kill every held entry at this edge (zeroed bubbles)
//   in_valid/in_ready, in_ctrl, in_data    - upstream handshake + payload
//   out_valid/out_ready, out_ctrl, out_data - downstream handshake + payload
//   occupancy        - number of held entries (0..2)
// SKID=1 adds a second (skid) entry so in_ready is a pure function of the
// state register and never depends on out_ready. SKID=0 is a single entry
// whose in_ready passes out_ready through combinationally.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NDATA  = NDATA_DEF,
  parameter int SKID   = 1
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy
);

  localparam int DW = NDATA * DATA_W;

  state_e state, state_nx;
  logic   accept, drain;
  logic   main_load, main_from_skid, skid_load;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DW-1:0]     main_data, skid_data, main_data_d;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? (state != ST_FULL2) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign occupancy = occ_of(state);

  always_ff @(posedge CLK) begin
    if (Reset || flush) state <= ST_EMPTY;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_nx  = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept && SKID != 0) begin
          // main is stalled: park the new entry behind it
          skid_load = 1'b1;
          state_nx  = ST_FULL2;
        end else if (drain) begin
          state_nx  = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_nx       = ST_FULL1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DW(DW)) u_main (
    .clk    (CLK),
    .rst    (Reset),
    .clr    (flush),
    .load   (main_load),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .ctrl_q (main_ctrl),
    .data_q (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DW(DW)) u_skid (
        .clk    (CLK),
        .rst    (Reset),
        .clr    (flush),
        .load   (skid_load),
        .ctrl_d (in_ctrl),
        .data_d (in_data),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data)
      );
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  // bubbles carry no control bits, so no write enable leaks downstream
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam int CW = 8;
  localparam int DW = 48;

  logic CLK = 1'b0;
  logic Reset, flush;
  always #5 CLK = ~CLK;

  // SKID=1 instance (a_*) and SKID=0 instance (b_*)
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  pipe_stage_elastic #(.CTRL_W(8), .DATA_W(16), .NDATA(3), .SKID(1)) dut_a (
    .CLK(CLK), .Reset(Reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_elastic #(.CTRL_W(8), .DATA_W(16), .NDATA(3), .SKID(0)) dut_b (
    .CLK(CLK), .Reset(Reset), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int w2, input int w1, input int w0);
    mk = {w2[15:0], w1[15:0], w0[15:0]};
  endfunction

  // advance one edge; outputs are then sampled 1 time unit after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] c,
                       input logic [DW-1:0] d, input logic [1:0] o, input logic r);
    chk({tag, ".valid"}, a_out_valid, v);
    chk({tag, ".ctrl"},  a_out_ctrl, c);
    chk({tag, ".data"},  a_out_data, d);
    chk({tag, ".occ"},   a_occ, o);
    chk({tag, ".rdy"},   a_in_ready, r);
  endtask

  task automatic send_a(input logic [7:0] c, input logic [DW-1:0] d);
    a_in_valid = 1'b1; a_in_ctrl = c; a_in_data = d;
  endtask

  initial begin
    flush = 0;
    a_in_valid = 0; a_in_ctrl = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_ctrl = 0; b_in_data = 0; b_out_ready = 0;

    // reset with junk on the inputs
    Reset = 1;
    a_in_valid = 1; a_in_ctrl = 8'hFF; a_in_data = {DW{1'b1}};
    b_in_valid = 1; b_in_ctrl = 8'hFF; b_in_data = {DW{1'b1}};
    step(); step();
    chk_a("rst_a", 0, 8'h00, '0, 2'd0, 1);
    chk("rst_b.valid", b_out_valid, 0);
    chk("rst_b.ctrl", b_out_ctrl, 0);
    chk("rst_b.data", b_out_data, 0);
    chk("rst_b.rdy", b_in_ready, 1);
    chk("rst_b.occ", b_occ, 0);
    Reset = 0;
    a_in_valid = 0; b_in_valid = 0;

    // streaming: one per cycle, visible right after its accept edge
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send_a(8'(i + 1), mk(i + 32, i + 16, i));
      step();
      chk_a($sformatf("strm%0d", i), 1, 8'(i + 1), mk(i + 32, i + 16, i), 2'd1, 1);
    end
    a_in_valid = 0;
    step();
    chk("strm_end.valid", a_out_valid, 0);
    chk("strm_end.ctrl", a_out_ctrl, 0);
    chk("strm_end.occ", a_occ, 0);

    // stall fills the skid entry
    a_out_ready = 0;
    send_a(8'hA1, mk(16'h1111, 16'h1111, 16'h1111));
    step();
    chk_a("stallA", 1, 8'hA1, mk(16'h1111, 16'h1111, 16'h1111), 2'd1, 1);
    send_a(8'hA2, mk(16'h2222, 16'h2222, 16'h2222));
    step();
    chk_a("stallB", 1, 8'hA1, mk(16'h1111, 16'h1111, 16'h1111), 2'd2, 0);
    send_a(8'hA3, mk(16'h3333, 16'h3333, 16'h3333));  // refused: in_ready low
    step();
    chk_a("stallhold", 1, 8'hA1, mk(16'h1111, 16'h1111, 16'h1111), 2'd2, 0);
    a_in_valid = 0;
    a_out_ready = 1;
    step();
    chk_a("drainB", 1, 8'hA2, mk(16'h2222, 16'h2222, 16'h2222), 2'd1, 1);
    step();
    chk("drain_end.valid", a_out_valid, 0);
    chk("drain_end.ctrl", a_out_ctrl, 0);
    chk("drain_end.occ", a_occ, 0);

    // flush with both entries held and an accept on the same edge
    a_out_ready = 0;
    send_a(8'hC3, mk(16'h3333, 16'h3333, 16'h3333));
    step();
    send_a(8'hC4, mk(16'h4444, 16'h4444, 16'h4444));
    step();
    chk("preflush.occ", a_occ, 2);
    send_a(8'hC5, mk(16'h5555, 16'h5555, 16'h5555));
    flush = 1;
    step();
    chk_a("flush", 0, 8'h00, '0, 2'd0, 1);
    flush = 0;
    a_in_valid = 0;
    a_out_ready = 1;
    step();
    chk_a("postflush", 0, 8'h00, '0, 2'd0, 1);

    // reset and flush together with an accept
    Reset = 1; flush = 1;
    send_a(8'hD6, mk(16'h6666, 16'h6666, 16'h6666));
    step();
    chk_a("prio", 0, 8'h00, '0, 2'd0, 1);
    Reset = 0; flush = 0;
    send_a(8'hD7, mk(16'h7777, 16'h7777, 16'h7777));
    step();
    chk_a("prio_next", 1, 8'hD7, mk(16'h7777, 16'h7777, 16'h7777), 2'd1, 1);
    a_in_valid = 0;
    step();
    chk("prio_end.valid", a_out_valid, 0);

    // SKID=0: combinational in_ready and replace-on-drain
    b_out_ready = 0;
    b_in_valid = 1; b_in_ctrl = 8'h11; b_in_data = mk(16'hAAAA, 16'hBBBB, 16'hCCCC);
    step();
    chk("b_load.valid", b_out_valid, 1);
    chk("b_load.ctrl", b_out_ctrl, 8'h11);
    chk("b_load.data", b_out_data, mk(16'hAAAA, 16'hBBBB, 16'hCCCC));
    chk("b_load.occ", b_occ, 1);
    b_in_ctrl = 8'h22; b_in_data = mk(16'h0102, 16'h0304, 16'h0506);
    #1;
    chk("b_stall.rdy", b_in_ready, 0);
    b_out_ready = 1;
    #1;
    chk("b_comb.rdy", b_in_ready, 1);
    step();
    chk("b_repl.ctrl", b_out_ctrl, 8'h22);
    chk("b_repl.data", b_out_data, mk(16'h0102, 16'h0304, 16'h0506));
    chk("b_repl.occ", b_occ, 1);
    b_out_ready = 0;
    b_in_ctrl = 8'h33; b_in_data = mk(16'h0909, 16'h0909, 16'h0909);
    step();
    chk("b_hold.ctrl", b_out_ctrl, 8'h22);
    chk("b_hold.data", b_out_data, mk(16'h0102, 16'h0304, 16'h0506));
    b_in_valid = 0;
    b_out_ready = 1;
    step();
    chk("b_end.valid", b_out_valid, 0);
    chk("b_end.ctrl", b_out_ctrl, 0);
    chk("b_end.occ", b_occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised inter-stage pipeline register: the successor to the fixed-width, enable-gated EX/MEM latch. It carries one control vector plus NDATA data words between stages under a valid/ready handshake. It optionally adds a one-entry skid buffer so backpressure never combinationally reaches the upstream stage. A flush input kills in-flight instructions and replaces them with zeroed bubbles. It is instantiated between every pipeline stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage parameters.

## Interface
- CTRL_W, 8, control-vector width (packed RegWrite, ALUSrc, ALUOP[2:0], MemWrite, MemRead, RegStore at EX/MEM)
- DATA_W, 16, width of each data word
- NDATA, 3, number of data words (ALUResult, 3rdArg, Rd at EX/MEM); must be ≥1
- SKID, 1, 1 = two-entry elastic stage with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- flush  in  1  kill all held entries this edge
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control vector
- in_data  in  NDATA*DATA_W  upstream data words, word 0 in LSBs
- out_valid  out  1  output entry holds a live instruction
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control vector; all-zero whenever out_valid=0
- out_data  out  NDATA*DATA_W  data words; all-zero after reset or flush until the next accept
- occupancy  out  2  entries held (0..2; never exceeds 1 when SKID=0)

## Operation
- Accept: in_valid & in_ready at the edge. Drain: out_valid & out_ready at the edge.
- Entries: main (drives outputs) and skid (SKID=1 only). Order is FIFO; the skid entry never bypasses main.
- SKID=1 state machine:
  - EMPTY: accept → FULL1.
  - FULL1:
    - accept & drain → FULL1 (main loaded with the new entry).
    - accept & !drain → FULL2 (new entry into skid).
    - drain only → EMPTY.
  - FULL2: drain → FULL1 (skid moves to main). No accept possible.
- SKID=1: in_ready = (state != FULL2), registered.
- SKID=0: in_ready = !out_valid | out_ready. Single entry EMPTY/FULL1.
- Priority: Reset > flush > accept/drain.
- flush: both entries are invalidated; ctrl and data are zeroed; state → EMPTY. A simultaneous accept is discarded. A simultaneous drain still counts downstream, because the outputs are valid during that cycle.
- Bubble rule: out_ctrl is forced to 0 when out_valid=0, so no write enable leaks downstream.
- No data transformation; widths pass through bit-exact.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 (both modes), state=EMPTY.
- Latency: accept at edge N → out_valid=1 with that payload from edge N through at least edge N+1.
- Throughput: 1 instruction/cycle sustained when out_ready=1.
- A stall (out_ready=0) holds out_ctrl/out_data stable; the payload must not change while out_valid & !out_ready.
- SKID=1: in_ready deasserts the cycle after the second entry is captured. At most one extra accept after out_ready falls.
- in_valid and in_ctrl/in_data are sampled only on an accept edge.
- Reset or flush mid-stall: outputs are zero on the next cycle regardless of out_ready.

## Structure
- pipe_pkg: CTRL_W default, named bit offsets of each control field, stage-default NDATA/DATA_W constants, state encoding (EMPTY, FULL1, FULL2).
- Sub-module pipe_slot: one ctrl+data register with load, clear and hold; instantiated once (SKID=0) or twice (SKID=1).

## Test plan
- Reset: assert Reset 2 cycles with in_valid=1, in_ctrl=8'hFF → out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: SKID=1, 8 back-to-back accepts with data words {i, i+16, i+32}, out_ready=1 → outputs appear in order, 1 cycle later, no gaps.
- Stall/skid: SKID=1, out_ready=0 while sending A=16'h1111 then B=16'h2222 → occupancy=2, in_ready=0, out_data holds A; release out_ready → A then B drained, in_ready=1.
- SKID=0 stall: out_ready=0 with out_valid=1 → in_ready=0 combinationally; out_ready=1 with in_valid=1 → replacement entry loaded at the same edge.
- Flush: occupancy=2 plus in_valid=1 at the flush edge → next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed entries never appear.
- Priority: Reset and flush asserted together with an accept → reset values result; the first instruction after deassertion appears with 1-cycle latency.
